// File: rtl/order_rx_fifo.sv
// Serial order receiver: synchronizes an asynchronous framed bit stream, assembles
// 32-bit orders MSB first and queues them in a small FIFO for a downstream consumer.
module order_rx_fifo #(
    parameter int CLKS_PER_BIT = 6,
    parameter int DEPTH        = 4
) (
    input  logic                     clk,
    input  logic                     CPU_RESETN,
    input  logic                     com_en,
    input  logic                     data_ping_in,
    output logic [31:0]              order_out,
    output logic                     order_valid,
    input  logic                     order_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     busy,
    output logic                     frame_err,
    output logic                     overflow
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int CYC_W   = $clog2(CLKS_PER_BIT);
    localparam int HALF_M1 = CLKS_PER_BIT / 2 - 1;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ALIGN    = 3'd1;
    localparam logic [2:0] S_SHIFT    = 3'd2;
    localparam logic [2:0] S_COMMIT   = 3'd3;
    localparam logic [2:0] S_WAIT_LOW = 3'd4;

    logic             com_meta_q, com_sync_q, com_prev_q;
    logic             dat_meta_q, dat_sync_q;
    logic [1:0]       fill_q;
    logic             armed_q, armed_d;
    logic [2:0]       state_q, state_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [5:0]       bit_q, bit_d;
    logic [31:0]      shift_q, shift_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             frame_err_q, frame_err_d;
    logic             overflow_q, overflow_d;
    logic [31:0]      mem_q [DEPTH];

    logic push, pop, rise, full;

    assign order_valid = (count_q != '0);
    assign order_out   = order_valid ? mem_q[rd_ptr_q] : 32'h0;
    assign fifo_count  = count_q;
    assign busy        = (state_q != S_IDLE);
    assign frame_err   = frame_err_q;
    assign overflow    = overflow_q;

    assign pop  = order_valid & order_ready;
    assign full = (count_q == CNT_W'(DEPTH));
    // A start edge only counts once com_en has been seen low after reset settled.
    assign rise = armed_q & com_sync_q & ~com_prev_q;

    always_comb begin
        armed_d     = armed_q | (fill_q[1] & ~com_sync_q);
        state_d     = state_q;
        cyc_d       = cyc_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        overflow_d  = 1'b0;
        push        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    state_d = S_ALIGN;
                    cyc_d   = '0;
                    bit_d   = '0;
                    shift_d = '0;
                end
            end
            S_ALIGN, S_SHIFT: begin
                if (!com_sync_q) begin
                    frame_err_d = 1'b1;
                    shift_d     = '0;
                    cyc_d       = '0;
                    bit_d       = '0;
                    state_d     = S_IDLE;
                end else if ((state_q == S_ALIGN && cyc_q == CYC_W'(HALF_M1)) ||
                             (state_q == S_SHIFT && cyc_q == CYC_W'(CLKS_PER_BIT - 1))) begin
                    shift_d = {shift_q[30:0], dat_sync_q};
                    cyc_d   = '0;
                    bit_d   = bit_q + 6'd1;
                    if (state_q == S_ALIGN) begin
                        state_d = S_SHIFT;
                    end else if (bit_q == 6'd31) begin
                        state_d = S_COMMIT;
                    end
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            S_COMMIT: begin
                if (!full || pop) begin
                    push = 1'b1;
                end else begin
                    overflow_d = 1'b1;
                end
                state_d = S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
                if (!com_sync_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            com_meta_q  <= 1'b0;
            com_sync_q  <= 1'b0;
            com_prev_q  <= 1'b0;
            dat_meta_q  <= 1'b0;
            dat_sync_q  <= 1'b0;
            fill_q      <= 2'b00;
            armed_q     <= 1'b0;
            state_q     <= S_IDLE;
            cyc_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            com_meta_q  <= com_en;
            com_sync_q  <= com_meta_q;
            com_prev_q  <= com_sync_q;
            dat_meta_q  <= data_ping_in;
            dat_sync_q  <= dat_meta_q;
            fill_q      <= {fill_q[0], 1'b1};
            armed_q     <= armed_d;
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    // Storage carries no reset; order_out is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

endmodule

// File: tb/tb_order_rx_fifo.sv
// Scoreboard bench for order_rx_fifo: drives serial frames and compares popped orders.
module tb_order_rx_fifo;

    localparam int CPB   = 6;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        CPU_RESETN;
    logic        com_en;
    logic        data_ping_in;
    logic [31:0] order_out;
    logic        order_valid;
    logic        order_ready;
    logic [2:0]  fifo_count;
    logic        busy;
    logic        frame_err;
    logic        overflow;

    order_rx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .CPU_RESETN   (CPU_RESETN),
        .com_en       (com_en),
        .data_ping_in (data_ping_in),
        .order_out    (order_out),
        .order_valid  (order_valid),
        .order_ready  (order_ready),
        .fifo_count   (fifo_count),
        .busy         (busy),
        .frame_err    (frame_err),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          err_cnt = 0, ovf_cnt = 0;
    int          exp_err = 0, exp_ovf = 0;
    logic [31:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Monitor: sample away from the active edge, pop the scoreboard on each transfer.
    always @(negedge clk) begin
        if (frame_err === 1'b1) err_cnt++;
        if (overflow === 1'b1)  ovf_cnt++;
        if (order_valid === 1'b1 && order_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pop", 32'd1, 32'd0);
            end else begin
                chk("order_out", order_out, exp_q.pop_front());
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // nbits < 32 aborts the frame; rst_bit >= 0 pulses reset at the start of that bit.
    task automatic send_frame(input logic [31:0] word, input int nbits, input int hold_bits,
                              input bit pop_commit, input int rst_bit);
        cycles(1);
        com_en = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_bit) begin
                CPU_RESETN = 1'b0;
                #1;
                chk("rst_order_out", order_out, 32'h0);
                chk("rst_valid", {31'd0, order_valid}, 32'd0);
                chk("rst_count", {29'd0, fifo_count}, 32'd0);
                chk("rst_busy", {31'd0, busy}, 32'd0);
                chk("rst_pulses", {30'd0, frame_err, overflow}, 32'd0);
                exp_q.delete();
                cycles(2);
                CPU_RESETN = 1'b1;
            end
            data_ping_in = word[31-i];
            cycles(CPB);
        end
        if (pop_commit) begin
            order_ready = 1'b1;
            cycles(1);
            order_ready = 1'b0;
        end
        if (hold_bits > 0) begin
            cycles(hold_bits * CPB);
            chk("busy_while_held", {31'd0, busy}, 32'd1);
        end
        com_en       = 1'b0;
        data_ping_in = 1'b0;
        if (rst_bit < 0) begin
            if (nbits == 32) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(word);
                else exp_ovf++;
            end else begin
                exp_err++;
            end
        end
        cycles(2 * CPB);
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        order_ready = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            cycles(1);
            if (exp_q.size() == 0) done = 1'b1;
        end
        order_ready = 1'b0;
        chk("drain_done", {31'd0, done}, 32'd1);
        cycles(1);
        chk("drain_count", {29'd0, fifo_count}, 32'd0);
        chk("drain_valid", {31'd0, order_valid}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        CPU_RESETN   = 1'b0;
        com_en       = 1'b0;
        data_ping_in = 1'b0;
        order_ready  = 1'b0;
        cycles(3);
        chk("reset_order_out", order_out, 32'h0);
        chk("reset_valid", {31'd0, order_valid}, 32'd0);
        chk("reset_count", {29'd0, fifo_count}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_pulses", {30'd0, frame_err, overflow}, 32'd0);
        CPU_RESETN = 1'b1;
        cycles(5);

        // Single frame, consumer stalled
        send_frame(32'h11004001, 32, 0, 1'b0, -1);
        chk("single_valid", {31'd0, order_valid}, 32'd1);
        chk("single_count", {29'd0, fifo_count}, 32'd1);
        chk("single_head", order_out, 32'h11004001);
        chk("single_err", err_cnt, 0);
        chk("single_ovf", ovf_cnt, 0);
        drain();

        // Five frames into a four-deep FIFO
        for (int f = 1; f <= 5; f++) send_frame(32'(f), 32, 0, 1'b0, -1);
        chk("fill_count", {29'd0, fifo_count}, 32'd4);
        chk("fill_ovf", ovf_cnt, 1);
        drain();

        // Aborted frame then a good one
        send_frame(32'hFFFF0000, 17, 0, 1'b0, -1);
        chk("abort_err", err_cnt, 1);
        chk("abort_count", {29'd0, fifo_count}, 32'd0);
        send_frame(32'hDEADBEEF, 32, 0, 1'b0, -1);
        chk("after_abort_count", {29'd0, fifo_count}, 32'd1);
        drain();

        // Full FIFO with a pop in the commit cycle
        for (int f = 0; f < 4; f++) send_frame(32'h10 + 32'(f), 32, 0, 1'b0, -1);
        send_frame(32'hA5A5A5A5, 32, 0, 1'b1, -1);
        chk("pop_commit_count", {29'd0, fifo_count}, 32'd4);
        chk("pop_commit_ovf", ovf_cnt, 1);
        drain();

        // Reset in the middle of a frame
        send_frame(32'h5555AAAA, 32, 0, 1'b0, 10);
        chk("rst_mid_count", {29'd0, fifo_count}, 32'd0);
        chk("rst_mid_err", err_cnt, 1);
        chk("rst_mid_ovf", ovf_cnt, 1);
        send_frame(32'hCAFEF00D, 32, 0, 1'b0, -1);
        chk("after_rst_count", {29'd0, fifo_count}, 32'd1);
        drain();

        // com_en held well past the frame
        send_frame(32'h0BADF00D, 32, 8, 1'b0, -1);
        chk("held_busy_low", {31'd0, busy}, 32'd0);
        chk("held_count", {29'd0, fifo_count}, 32'd1);
        drain();

        chk("total_err", err_cnt, exp_err);
        chk("total_ovf", ovf_cnt, exp_ovf);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/order_rx_fifo.md
ORDER_RX_FIFO -- requirements
Module: order_rx_fifo

Interface
REQ-001 Parameter CLKS_PER_BIT, default 6, clk cycles per serial bit (even, >=4).
REQ-002 Parameter DEPTH, default 4, order FIFO entries (power of two).
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 CPU_RESETN  input  1  reset, asynchronous, active-low.
REQ-005 com_en  input  1  async frame enable from serializer; high for the whole 32-bit frame.
REQ-006 data_ping_in  input  1  async serial order data, MSB first.
REQ-007 order_out  output  32  order word at FIFO head.
REQ-008 order_valid  output  1  FIFO non-empty; order_out valid.
REQ-009 order_ready  input  1  consumer accepts head when high with order_valid.
REQ-010 fifo_count  output  clog2(DEPTH)+1  stored orders.
REQ-011 busy  output  1  frame reception in progress (state not IDLE).
REQ-012 frame_err  output  1  one-cycle pulse: frame aborted.
REQ-013 overflow  output  1  one-cycle pulse: complete frame dropped, FIFO full.

Function
REQ-014 com_en and data_ping_in SHALL each pass a 2-flop synchronizer before use.
REQ-015 FSM states SHALL be IDLE, ALIGN, SHIFT, COMMIT, WAIT_LOW.
REQ-016 IDLE -> ALIGN on synchronized com_en rising edge (low last cycle, high now).
REQ-017 ALIGN waits CLKS_PER_BIT/2-1 cycles, then samples bit 31 and enters SHIFT.
REQ-018 SHIFT samples one bit every CLKS_PER_BIT cycles into a 32-bit left-shift register; after the 32nd sample -> COMMIT.
REQ-019 A 6-bit bit counter and a cycle counter sized for CLKS_PER_BIT SHALL clear on ALIGN entry.
REQ-020 If synchronized com_en is low in any ALIGN/SHIFT cycle: frame_err pulses next cycle, shift data discarded, -> IDLE.
REQ-021 COMMIT (one cycle) writes the word if FIFO not full or a pop occurs that cycle; otherwise overflow pulses, word dropped; -> WAIT_LOW.
REQ-022 WAIT_LOW -> IDLE when synchronized com_en is low; a com_en still high never starts a second frame.
REQ-023 Pop SHALL occur when order_valid & order_ready; order_out SHALL then show the next entry the following cycle.
REQ-024 Push and pop in the same cycle SHALL both take effect; fifo_count unchanged.
REQ-025 Pointers SHALL wrap modulo DEPTH; fifo_count never exceeds DEPTH nor underflows.
REQ-026 order_ready with empty FIFO SHALL have no effect.
REQ-027 First-in first-out order SHALL be preserved across wrap.
REQ-028 Latency: order_valid rises 1 cycle after COMMIT when FIFO was empty.

Reset
REQ-029 Asserting CPU_RESETN low SHALL immediately force IDLE, clear pointers, counters, shift register and synchronizers.
REQ-030 During reset: order_out=0, order_valid=0, fifo_count=0, busy=0, frame_err=0, overflow=0.
REQ-031 Reset mid-frame SHALL discard the partial frame; no frame_err or overflow pulse.
REQ-032 After release, a frame whose com_en was already high SHALL be ignored until com_en goes low then high.

Verification
REQ-033 Send 0x11004001 with CLKS_PER_BIT=6, order_ready=0 -> order_valid=1, order_out=0x11004001, fifo_count=1, no pulses.
REQ-034 Send 5 frames 0x1..0x5 with order_ready=0, DEPTH=4 -> fifo_count=4, one overflow pulse at frame 5; drain yields 0x1,0x2,0x3,0x4.
REQ-035 Drop com_en after 17 bits -> frame_err one pulse, fifo_count unchanged, next full frame 0xDEADBEEF received correctly.
REQ-036 FIFO full, order_ready=1 during COMMIT of 0xA5A5A5A5 -> no overflow, fifo_count stays 4, 0xA5A5A5A5 last out.
REQ-037 Assert CPU_RESETN low at bit 10 of a frame -> all outputs 0 immediately; no pulses; next frame received intact.
REQ-038 Hold com_en high for 40 bit periods with one frame -> exactly one order stored, busy low only after com_en falls.
